stim_resp_checker: RTL and testbench
====================================

// Module: stim_resp_checker
// PURPOSE
//  Synthesisable self-checking stimulus engine: generates N vectors in a selectable pattern and drives them into a DUT over a valid/ready port.
//  Checks the in-order DUT loopback responses against the expected vectors, counts mismatches and reports pass/fail.
//  Sits between a test controller and any streaming DUT.
//  Parametrised successor of the fixed, initial-block bench: width, outstanding depth, pattern mode and timeout are configurable.
// PARAMETERS
//  WIDTH    8      data width of stimulus and response (>=2)
//  DEPTH    4      max outstanding (sent, unanswered) vectors; power of 2, >=2
//  CNT_W    16     width of num_vectors, err_count, first_err_idx
//  POLY     8'hB8  Galois LFSR tap mask (WIDTH bits) for mode LFSR
//  SEED     8'h01  LFSR seed; must be nonzero
//  TIMEOUT  256    cycles without a response while vectors are outstanding -> abort
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  start          in   1      1-cycle pulse; accepted only in IDLE or DONE
//  mode           in   2      0 COUNT, 1 WALK1, 2 LFSR, 3 ALT (0x55../0xAA..); sampled on start
//  num_vectors    in   CNT_W  vectors to send; sampled on start
//  stim_data      out  WIDTH  vector to DUT
//  stim_valid     out  1      stim_data valid
//  stim_ready     in   1      DUT accepts when valid&ready
//  resp_data      in   WIDTH  DUT response
//  resp_valid     in   1      response strobe (always accepted, no backpressure)
//  busy           out  1      high in RUN/DRAIN
//  done           out  1      level, high in DONE until next start
//  pass           out  1      valid when done: err_count==0 && !timeout
//  timeout        out  1      run aborted by TIMEOUT
//  err_count      out  CNT_W  mismatches + spurious responses, saturating
//  first_err_idx  out  CNT_W  response index (0-based) of first error; all-ones if none
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE, all outputs 0 except first_err_idx = all-ones. Expected FIFO empty.
//  - FSM states are IDLE, RUN, DRAIN, DONE.
//  - IDLE/DONE + start: latch mode and num_vectors, clear counters/flags, go to RUN. If num_vectors==0, go to DONE next cycle with pass=1.
//  - RUN: stim_valid=1 while sent<num_vectors and FIFO not full.
//    - Each handshake pushes stim_data to the FIFO and advances the pattern in the same cycle (1-cycle turnaround, back-to-back allowed).
//    - stim_data is held stable while valid&!ready.
//    - When the last vector is sent, go to DRAIN.
//  - Patterns (vector k):
//    - COUNT: k mod 2^WIDTH.
//    - WALK1: 1<<(k mod WIDTH).
//    - LFSR: SEED, then Galois shift (lsb out; XOR POLY if lsb=1).
//    - ALT: 0x55.. for even k, 0xAA.. for odd k.
//  - Response handling: resp_valid with FIFO non-empty pops the head and compares it against resp_data.
//    - A mismatch increments err_count; the first error records the response index.
//    - resp_valid with FIFO empty is a spurious response: it counts as an error and does not pop.
//    - Push and pop in the same cycle are both honoured; occupancy is unchanged, including when the FIFO is full.
//  - DRAIN: go to DONE when the FIFO is empty.
//  - Timeout counter: resets on any resp_valid or on send; counts while the FIFO is non-empty.
//    - At TIMEOUT (RUN or DRAIN), set timeout=1, flush the FIFO, go to DONE.
//  - DONE: done=1, pass registered on entry. Responses arriving in DONE are spurious: counted, but pass is not changed.
//  - start in RUN/DRAIN is ignored.
//  - err_count saturates at all-ones.
//  - Reset mid-run aborts immediately to IDLE. No vector is presented after reset.
// STRUCTURE
//  - Package stim_resp_pkg: mode localparams (MODE_COUNT..MODE_ALT), FSM state encodings, next_pattern function.
//  - Sub-module sync_fifo (WIDTH, DEPTH):
//    - Ports: push, pop, din, dout, full, empty, flush.
//    - Pointers wrap with an extra MSB for full/empty detection.
// TESTING
//  1. COUNT, N=5, ready=1, DUT=1-cycle echo -> stim 0,1,2,3,4; done, pass=1, err_count=0, first_err_idx=FFFF.
//  2. LFSR WIDTH=8 POLY=B8 SEED=01, N=3, echo -> stim 01,B8,5C; pass=1.
//  3. WALK1, N=10, DUT corrupts 4th response (^01) -> err_count=1, first_err_idx=3, pass=0.
//  4. ready toggling, DUT delay 6 cycles, DEPTH=4 -> stim_valid drops when 4 outstanding; no vector lost; pass=1.
//  5. DUT never responds, N=2 -> timeout=1, done 256 cycles after last send, pass=0.
//  6. Reset low mid-RUN -> next cycle busy=0, stim_valid=0; N=0 start -> done next cycle, pass=1.

Source files
------------

// File: rtl/stim_resp_pkg.sv
// Shared definitions for the stimulus/response checker: pattern modes, FSM
// states and the pattern generator used for both the first and next vector.
package stim_resp_pkg;

  localparam int MAX_W = 64;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_WALK1 = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    if (width >= MAX_W) begin
      return '1;
    end else begin
      return (64'd1 << width) - 64'd1;
    end
  endfunction

  function automatic logic [MAX_W-1:0] first_pattern(input logic [1:0] mode, input int width,
                                                     input logic [MAX_W-1:0] seed);
    case (mode)
      MODE_COUNT: return 64'd0;
      MODE_WALK1: return 64'd1;
      MODE_LFSR:  return seed & width_mask(width);
      MODE_ALT:   return 64'h5555_5555_5555_5555 & width_mask(width);
      default:    return 64'd0;
    endcase
  endfunction

  // WALK1 is a rotate so the single one wraps back to bit 0 after WIDTH steps.
  function automatic logic [MAX_W-1:0] next_pattern(input logic [1:0] mode,
                                                    input logic [MAX_W-1:0] cur, input int width,
                                                    input logic [MAX_W-1:0] poly);
    logic [MAX_W-1:0] mask;
    mask = width_mask(width);
    case (mode)
      MODE_COUNT: return (cur + 64'd1) & mask;
      MODE_WALK1: return ((cur << 1) | (cur >> (width - 1))) & mask;
      MODE_LFSR:  return cur[0] ? (((cur >> 1) ^ poly) & mask) : (cur >> 1);
      MODE_ALT:   return ~cur & mask;
      default:    return cur;
    endcase
  endfunction

endpackage

// File: rtl/stim_resp_checker_fifo.sv
// Expected-vector FIFO: first-word fall-through, pointers carry an extra MSB
// so full and empty are distinguishable; flush empties it in one cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push_s = push && (!full || pop);
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push_s) begin
        wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = rd_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_d = rd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/stim_resp_checker.sv
// Stimulus engine plus in-order response checker: drives patterned vectors
// over valid/ready, compares loopback responses and reports pass/fail.
module stim_resp_checker
  import stim_resp_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] POLY    = 8'hB8,
  parameter logic [WIDTH-1:0] SEED    = 8'h01,
  parameter int               TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_vectors,
  output logic [WIDTH-1:0] stim_data,
  output logic             stim_valid,
  input  logic             stim_ready,
  input  logic [WIDTH-1:0] resp_data,
  input  logic             resp_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int             TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] num_q, num_d, sent_q, sent_d, resp_idx_q, resp_idx_d;
  logic [CNT_W-1:0] err_q, err_d, first_err_q, first_err_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d, pass_q, pass_d;

  logic             start_ok_s, fire_s, pop_s, resp_err_s, to_hit_s, stim_valid_s;
  logic             full_s, empty_s;
  logic [WIDTH-1:0] head_s;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fire_s),
    .pop   (pop_s),
    .flush (to_hit_s),
    .din   (pat_q),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign fire_s     = stim_valid_s && stim_ready;
  assign pop_s      = resp_valid && !empty_s;
  assign resp_err_s = resp_valid && (empty_s || (head_s != resp_data));
  // A send or response in the expiring cycle counts as progress, so no abort then.
  assign to_hit_s   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !empty_s &&
                      !resp_valid && !fire_s && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = (num_vectors == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (to_hit_s) begin
          state_d = ST_DONE;
        end else if (fire_s && ((sent_q + CNT_W'(1)) == num_q)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (to_hit_s || empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stim_valid_s = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy         = 1'b1;
        stim_valid_s = (sent_q < num_q) && !full_s;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  assign stim_valid    = stim_valid_s;
  assign stim_data     = pat_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign first_err_idx = first_err_q;

  always_comb begin
    mode_d      = mode_q;
    num_d       = num_q;
    sent_d      = sent_q;
    pat_d       = pat_q;
    resp_idx_d  = resp_idx_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    to_cnt_d    = to_cnt_q;
    if (start_ok_s) begin
      mode_d      = mode;
      num_d       = num_vectors;
      sent_d      = '0;
      pat_d       = WIDTH'(first_pattern(mode, WIDTH, MAX_W'(SEED)));
      resp_idx_d  = '0;
      err_d       = '0;
      first_err_d = '1;
      timeout_d   = 1'b0;
      pass_d      = (num_vectors == '0);
      to_cnt_d    = '0;
    end else begin
      if (fire_s) begin
        sent_d = sent_q + CNT_W'(1);
        pat_d  = WIDTH'(next_pattern(mode_q, MAX_W'(pat_q), WIDTH, MAX_W'(POLY)));
      end else begin
        sent_d = sent_q;
        pat_d  = pat_q;
      end
      if (resp_valid) begin
        resp_idx_d = resp_idx_q + CNT_W'(1);
      end else begin
        resp_idx_d = resp_idx_q;
      end
      // err_q==0 marks "no error yet"; saturation never returns it to zero.
      if (resp_err_s) begin
        err_d = (err_q == '1) ? err_q : (err_q + CNT_W'(1));
        if (err_q == '0) begin
          first_err_d = resp_idx_q;
        end else begin
          first_err_d = first_err_q;
        end
      end else begin
        err_d = err_q;
      end
      if (fire_s || resp_valid || empty_s) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
      if (to_hit_s) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
        pass_d = (err_d == '0) && !timeout_d;
      end else begin
        pass_d = pass_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= MODE_COUNT;
      num_q       <= '0;
      sent_q      <= '0;
      pat_q       <= '0;
      resp_idx_q  <= '0;
      err_q       <= '0;
      first_err_q <= '1;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      mode_q      <= mode_d;
      num_q       <= num_d;
      sent_q      <= sent_d;
      pat_q       <= pat_d;
      resp_idx_q  <= resp_idx_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_stim_resp_checker.sv
// Bench for stim_resp_checker: emulates a delaying/corrupting loopback DUT and
// checks vectors, handshake behaviour and verdicts against a reference model.
module tb_stim_resp_checker;
  import stim_resp_pkg::*;

  localparam int         W  = 8;
  localparam int         D  = 4;
  localparam int         CW = 16;
  localparam logic [7:0] POLY_C = 8'hB8;
  localparam logic [7:0] SEED_C = 8'h01;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] num_vectors;
  logic [W-1:0]  stim_data;
  logic          stim_valid;
  logic          stim_ready;
  logic [W-1:0]  resp_data;
  logic          resp_valid;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] err_count, first_err_idx;

  always #5 clk = ~clk;

  stim_resp_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .POLY(POLY_C), .SEED(SEED_C),
                      .TIMEOUT(256)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_vectors(num_vectors),
    .stim_data(stim_data), .stim_valid(stim_valid), .stim_ready(stim_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         t;
  } pend_t;
  pend_t      pend[$];
  logic [7:0] got[$];

  typedef struct {
    logic [1:0] md;
    int         n;
    int         rpct;
    int         dly;
    int         cidx;
    bit         nores;
    int         exp_err;
    logic [15:0] exp_first;
    bit         exp_pass;
    bit         exp_to;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_vec(input logic [1:0] md, input int k);
    logic [7:0] v;
    case (md)
      MODE_COUNT: return 8'(k % 256);
      MODE_WALK1: return 8'(1 << (k % 8));
      MODE_ALT:   return (k % 2 == 0) ? 8'h55 : 8'hAA;
      default: begin
        v = SEED_C;
        for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? POLY_C : 8'h00);
        return v;
      end
    endcase
  endfunction

  // One complete run; the loopback emulator and protocol checks run at negedge.
  task automatic run_test(input logic [1:0] md, input int n, input int rpct, input int dly,
                          input int cidx, input bit nores, input int rnd_pct,
                          output int inj_err, output int inj_first,
                          output int last_fire, output int done_at);
    int fired, resp_n, occ, bad_valid, bad_hold, guard;
    bit prev_stall, exp_valid, fire;
    logic [7:0] prev_d, rd;
    fired = 0; resp_n = 0; bad_valid = 0; bad_hold = 0; guard = 0;
    prev_stall = 1'b0; prev_d = 8'h00;
    inj_err = 0; inj_first = -1; last_fire = -1; done_at = -1;
    pend.delete();
    got.delete();
    @(negedge clk);
    mode = md; num_vectors = CW'(n); start = 1'b1; stim_ready = 1'b0; resp_valid = 1'b0;
    while (guard < 5000) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (done === 1'b1) begin
        done_at = cyc;
        break;
      end
      occ = fired - resp_n;
      exp_valid = (fired < n) && (occ < D);
      if (stim_valid !== exp_valid) bad_valid++;
      if (prev_stall && ((stim_valid !== 1'b1) || (stim_data !== prev_d))) bad_hold++;
      stim_ready = ($urandom_range(99) < rpct);
      fire = (stim_valid === 1'b1) && stim_ready;
      prev_stall = (stim_valid === 1'b1) && !stim_ready;
      prev_d = stim_data;
      if (fire) begin
        got.push_back(stim_data);
        pend.push_back('{stim_data, cyc});
        fired++;
        last_fire = cyc;
      end
      resp_valid = 1'b0;
      resp_data  = 8'h00;
      if (!nores && (pend.size() > 0) && (pend[0].t + dly <= cyc)) begin
        rd = pend.pop_front().d;
        if ((resp_n == cidx) || ($urandom_range(99) < rnd_pct)) begin
          rd = rd ^ 8'($urandom_range(255, 1));
          inj_err++;
          if (inj_first < 0) inj_first = resp_n;
        end
        resp_valid = 1'b1;
        resp_data  = rd;
        resp_n++;
      end
    end
    stim_ready = 1'b0;
    resp_valid = 1'b0;
    check("done_reached", (done_at >= 0), 1);
    check("sent_count", fired, n);
    check("valid_protocol_violations", bad_valid, 0);
    check("hold_violations", bad_hold, 0);
    for (int k = 0; k < got.size(); k++) check($sformatf("vec%0d", k), got[k], ref_vec(md, k));
    check("busy_in_done", busy, 1'b0);
  endtask

  vec_t tbl[7];

  initial begin
    int ie, ifst, lf, da;
    logic [1:0] rmd;
    tbl[0] = '{MODE_COUNT, 5,   100, 1, -1, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0};
    tbl[1] = '{MODE_LFSR,  3,   100, 1, -1, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{MODE_WALK1, 10,  100, 1, 3,  1'b0, 1, 16'h0003, 1'b0, 1'b0};
    tbl[3] = '{MODE_COUNT, 20,  70,  6, -1, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{MODE_ALT,   2,   100, 1, -1, 1'b1, 0, 16'hFFFF, 1'b0, 1'b1};
    tbl[5] = '{MODE_ALT,   9,   60,  3, 8,  1'b0, 1, 16'h0008, 1'b0, 1'b0};
    tbl[6] = '{MODE_COUNT, 300, 100, 2, -1, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0};

    reset = 1'b0; start = 1'b0; mode = 2'd0; num_vectors = '0;
    stim_ready = 1'b0; resp_valid = 1'b0; resp_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_stim_valid", stim_valid, 1'b0);
    check("rst_stim_data", stim_data, 8'h00);
    check("rst_err_count", err_count, 16'h0000);
    check("rst_first_err", first_err_idx, 16'hFFFF);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_test(tbl[i].md, tbl[i].n, tbl[i].rpct, tbl[i].dly, tbl[i].cidx, tbl[i].nores, 0,
               ie, ifst, lf, da);
      check($sformatf("t%0d_err_count", i), err_count, tbl[i].exp_err);
      check($sformatf("t%0d_first_err", i), first_err_idx, tbl[i].exp_first);
      check($sformatf("t%0d_pass", i), pass, tbl[i].exp_pass);
      check($sformatf("t%0d_timeout", i), timeout, tbl[i].exp_to);
      // Abort edge comes 256 edges after the send edge; seen at the following negedge.
      if (tbl[i].nores) check($sformatf("t%0d_timeout_latency", i), da - lf, 257);
    end

    // LFSR sequence against literal values, then a spurious response in DONE.
    run_test(MODE_LFSR, 3, 100, 1, -1, 1'b0, 0, ie, ifst, lf, da);
    check("lfsr_v0", got[0], 8'h01);
    check("lfsr_v1", got[1], 8'hB8);
    check("lfsr_v2", got[2], 8'h5C);
    check("lfsr_pass", pass, 1'b1);
    resp_valid = 1'b1; resp_data = 8'h00;
    @(negedge clk);
    resp_valid = 1'b0;
    check("spurious_err_count", err_count, 16'h0001);
    check("spurious_first_err", first_err_idx, 16'h0003);
    check("spurious_pass_kept", pass, 1'b1);
    check("spurious_done_kept", done, 1'b1);

    // start during RUN is ignored; then reset mid-run and a zero-length run.
    mode = MODE_COUNT; num_vectors = 16'd8; start = 1'b1; stim_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("run_busy", busy, 1'b1);
    check("run_stim_valid", stim_valid, 1'b1);
    check("run_first_vec", stim_data, 8'h00);
    mode = MODE_ALT; num_vectors = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_ignored_busy", busy, 1'b1);
    check("restart_ignored_data", stim_data, 8'h00);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_stim_valid", stim_valid, 1'b0);
    check("midrst_first_err", first_err_idx, 16'hFFFF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("postrst_busy", busy, 1'b0);
    check("postrst_stim_valid", stim_valid, 1'b0);
    check("postrst_done", done, 1'b0);
    num_vectors = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_pass", pass, 1'b1);
    check("zero_busy", busy, 1'b0);

    // Randomised runs against the loopback model's own error bookkeeping.
    for (int r = 0; r < 15; r++) begin
      rmd = 2'($urandom_range(3));
      run_test(rmd, $urandom_range(30, 1), $urandom_range(100, 30), $urandom_range(8, 1),
               -1, 1'b0, 10, ie, ifst, lf, da);
      check($sformatf("r%0d_err_count", r), err_count, ie);
      check($sformatf("r%0d_first_err", r), first_err_idx,
            (ifst < 0) ? 32'h0000_FFFF : ifst);
      check($sformatf("r%0d_pass", r), pass, (ie == 0));
      check($sformatf("r%0d_timeout", r), timeout, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
